// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of word-aligned stores draining to data memory
// in program order, with a load-overlap hazard check against all pending words.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    input  logic [3:0]               st_be,
    output logic                     st_stall,
    input  logic                     ld_req,
    input  logic [31:0]              ld_addr,
    output logic                     ld_hazard,
    output logic                     mem_valid,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    input  logic                     mem_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [29:0]    addr_mem [DEPTH];
    logic [31:0]    data_mem [DEPTH];
    logic [3:0]     be_mem   [DEPTH];

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic           full;
    logic           st_req;
    logic           enq;
    logic           deq;
    logic [DEPTH-1:0] slot_hit;
    logic           unused_addr_bits;

    assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

    assign full   = (count_q == FULL_COUNT);
    assign empty  = (count_q == '0);
    assign st_req = (st_be != 4'b0000);
    assign enq    = st_req && !full;
    assign deq    = !empty && mem_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (enq && !deq) begin
            count_d = count_q + CW'(1);
        end else if (deq && !enq) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: validity is carried entirely by count_q.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[wr_ptr_q] <= st_addr[31:2];
            data_mem[wr_ptr_q] <= st_data;
            be_mem[wr_ptr_q]   <= st_be;
        end
    end

    assign st_stall  = st_req && full;
    assign count     = count_q;
    assign mem_valid = !empty;
    assign mem_addr  = mem_valid ? {addr_mem[rd_ptr_q], 2'b00} : '0;
    assign mem_wdata = mem_valid ? data_mem[rd_ptr_q] : '0;
    assign mem_be    = mem_valid ? be_mem[rd_ptr_q] : '0;

    // A slot is live when its distance from the head is below the occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            localparam logic [AW-1:0] SLOT = AW'(gi);
            logic [AW-1:0] age;
            logic          live;
            assign age          = SLOT - rd_ptr_q;
            assign live         = ({1'b0, age} < count_q);
            assign slot_hit[gi] = live && (addr_mem[gi] == ld_addr[31:2]);
        end
    endgenerate

    assign ld_hazard = ld_req && (slot_hit != '0);

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] st_addr, st_data, ld_addr;
    logic [3:0]  st_be;
    logic        ld_req, mem_ready;
    logic        st_stall, ld_hazard, mem_valid, empty;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .st_addr(st_addr), .st_data(st_data), .st_be(st_be), .st_stall(st_stall),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    ent_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of stores in program order.
    always @(posedge clk or posedge rst) begin
        bit do_enq, do_deq;
        ent_t e;
        if (rst) begin
            q.delete();
        end else begin
            do_deq = (q.size() != 0) && mem_ready;
            do_enq = (st_be != 4'b0) && (q.size() < DEPTH);
            if (do_deq) begin
                e = q.pop_front();
                $display("deq addr=%h data=%h be=%b", {e.a, 2'b00}, e.d, e.be);
            end
            if (do_enq) begin
                e.a = st_addr[31:2];
                e.d = st_data;
                e.be = st_be;
                q.push_back(e);
                $display("enq addr=%h data=%h be=%b", st_addr, st_data, st_be);
            end
        end
    end

    always @(negedge clk) begin
        logic        hit;
        logic [31:0] e_addr, e_data;
        logic [3:0]  e_be;
        hit = 1'b0;
        foreach (q[i]) if (q[i].a == ld_addr[31:2]) hit = 1'b1;
        e_addr = (q.size() != 0) ? {q[0].a, 2'b00} : 32'h0;
        e_data = (q.size() != 0) ? q[0].d : 32'h0;
        e_be   = (q.size() != 0) ? q[0].be : 4'h0;
        chk("m_count", 32'(count), 32'(q.size()));
        chk("m_empty", 32'(empty), 32'(q.size() == 0));
        chk("m_mem_valid", 32'(mem_valid), 32'(q.size() != 0));
        chk("m_mem_addr", mem_addr, e_addr);
        chk("m_mem_wdata", mem_wdata, e_data);
        chk("m_mem_be", 32'(mem_be), 32'(e_be));
        chk("m_st_stall", 32'(st_stall), 32'((st_be != 4'b0) && (q.size() == DEPTH)));
        chk("m_ld_hazard", 32'(ld_hazard), 32'(ld_req && hit));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_addr = a;
        st_data = d;
        st_be   = be;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, acc;
        rst = 1'b1;
        store(32'h0, 32'h0, 4'h0);
        ld_req = 1'b0; ld_addr = 32'h0; mem_ready = 1'b0;

        // Reset state, with a store request that must be ignored.
        store(32'h80, 32'h1234_5678, 4'hF);
        repeat (2) @(posedge clk);
        neg();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_stall", 32'(st_stall), 32'd0);
        cyc();
        rst = 1'b0;
        st_be = 4'h0;
        $display("phase: single word store");

        mem_ready = 1'b1;
        store(32'h104, 32'hDEADBEEF, 4'b1111);
        cyc();
        st_be = 4'h0;
        neg();
        chk("sw_valid", 32'(mem_valid), 32'd1);
        chk("sw_addr", mem_addr, 32'h104);
        chk("sw_data", mem_wdata, 32'hDEADBEEF);
        cyc();
        neg();
        chk("sw_empty_after", 32'(empty), 32'd1);

        $display("phase: fill and stall");
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            store(32'h41 + 32'(4 * i), 32'(i + 1) << 8, 4'b0010);
            cyc();
        end
        store(32'h51, 32'h0000_0500, 4'b0010);
        neg();
        chk("fill_count4", 32'(count), 32'd4);
        chk("fill_stall5", 32'(st_stall), 32'd1);
        cyc();
        mem_ready = 1'b1;
        k = 0;
        acc = -1;
        for (int it = 0; it < 20 && k < 5; it++) begin
            neg();
            if (mem_valid) begin
                chk("drain_order", mem_addr, 32'h40 + 32'(4 * k));
                k++;
            end
            if (st_be != 4'h0 && !st_stall) acc = it;
            cyc();
            if (acc == it) st_be = 4'h0;
        end
        chk("drain_total", 32'(k), 32'd5);
        chk("fifth_accept_iter", 32'(acc), 32'd1);
        neg();
        chk("drain_empty", 32'(empty), 32'd1);
        cyc();

        $display("phase: load hazard");
        mem_ready = 1'b0;
        store(32'h202, 32'hBEEF0000, 4'b1100);
        cyc();
        st_be = 4'h0;
        ld_req = 1'b1;
        ld_addr = 32'h200;
        neg();
        chk("hz_same_word", 32'(ld_hazard), 32'd1);
        cyc();
        ld_addr = 32'h204;
        neg();
        chk("hz_next_word", 32'(ld_hazard), 32'd0);
        cyc();
        ld_addr = 32'h200;
        mem_ready = 1'b1;
        neg();
        chk("hz_draining_head", 32'(ld_hazard), 32'd1);
        cyc();
        neg();
        chk("hz_after_drain", 32'(ld_hazard), 32'd0);
        cyc();
        mem_ready = 1'b0;
        store(32'h300, 32'h1, 4'b0001);
        ld_addr = 32'h300;
        neg();
        chk("hz_same_cycle_enq", 32'(ld_hazard), 32'd0);
        cyc();
        st_be = 4'h0;
        neg();
        chk("hz_after_enq", 32'(ld_hazard), 32'd1);
        cyc();
        ld_req = 1'b0;
        mem_ready = 1'b1;
        cyc();

        $display("phase: steady enqueue+dequeue wrap");
        mem_ready = 1'b0;
        store(32'h1000, 32'hA000_0000, 4'hF);
        cyc();
        store(32'h1004, 32'hA000_0001, 4'hF);
        cyc();
        st_be = 4'h0;
        neg();
        chk("wrap_start_count", 32'(count), 32'd2);
        cyc();
        mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            store(32'h1008 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'hF);
            neg();
            chk("wrap_count", 32'(count), 32'd2);
            chk("wrap_head", mem_addr, 32'h1000 + 32'(4 * i));
            cyc();
        end
        st_be = 4'h0;
        neg();
        chk("wrap_tail0", mem_addr, 32'h1028);
        chk("wrap_tail0_data", mem_wdata, 32'hB000_0008);
        cyc();
        neg();
        chk("wrap_tail1", mem_addr, 32'h102C);
        cyc();
        neg();
        chk("wrap_empty", 32'(empty), 32'd1);
        cyc();

        $display("phase: async reset mid-operation");
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            store(32'h5000 + 32'(4 * i), 32'(i), 4'hF);
            cyc();
        end
        st_be = 4'h0;
        neg();
        chk("pre_rst_count", 32'(count), 32'd3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(mem_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_addr", mem_addr, 32'h0);
        #1 rst = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            neg();
            chk("post_rst_valid", 32'(mem_valid), 32'd0);
            cyc();
        end

        $display("phase: head hold under backpressure");
        mem_ready = 1'b0;
        store(32'h2008, 32'hCAFEF00D, 4'b0110);
        cyc();
        for (int i = 0; i < 6; i++) begin
            if (i < 3) store(32'h3000 + 32'(4 * i), 32'(i), 4'hF);
            else st_be = 4'h0;
            neg();
            chk("hold_addr", mem_addr, 32'h2008);
            chk("hold_data", mem_wdata, 32'hCAFEF00D);
            chk("hold_be", 32'(mem_be), 32'h6);
            cyc();
        end
        st_be = 4'h0;
        mem_ready = 1'b1;
        repeat (4) cyc();
        neg();
        chk("final_empty", 32'(empty), 32'd1);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
